// File: rtl/pc_sequencer.sv
// Next-PC sequencer for the MIPS32 fetch stage: owns the PC and picks sequential, branch, jump or hold.
// Optional exception redirect (exc_req/epc) is compiled in when PCSEQ_EXCEPTION_EN is defined.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp,
    input  logic [31:0] jmp_target,
`ifdef PCSEQ_EXCEPTION_EN
    input  logic        exc_req,
    output logic [31:0] epc,
`endif
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        if_valid,
    output logic        flush,
    output logic        align_err
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [2:0] FLUSH_CNT_INIT = 3'(FLUSH_CYCLES);

    // Parameter sanity: bubble count must fit the 3-bit counter and the vector must be word aligned.
    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7) begin : g_bad_flush_cycles
        $error("pc_sequencer: FLUSH_CYCLES must be in 1..7");
    end
    if (EXC_VECTOR[1:0] != 2'b00) begin : g_bad_exc_vector
        $error("pc_sequencer: EXC_VECTOR must be word aligned");
    end

    state_t      state_reg;
    logic [31:0] pc_reg;
    logic [2:0]  flush_cnt_reg;
    logic        flush_reg;
    logic        align_err_reg;

    logic        redirect;
    logic [31:0] redirect_target;

`ifdef PCSEQ_EXCEPTION_EN
    logic [31:0] epc_reg;
    logic        exc_pend_reg;
    logic        exc_take;

    // A request seen during BOOT is remembered and serviced on the first RUN cycle.
    assign exc_take = exc_req | exc_pend_reg;
    assign epc      = epc_reg;
`endif

    // Branch resolves in EX and is older than the jump in ID, so it wins.
    always_comb begin
        redirect        = 1'b0;
        redirect_target = br_target;
        if (br_taken) begin
            redirect        = 1'b1;
            redirect_target = br_target;
        end else if (jmp) begin
            redirect        = 1'b1;
            redirect_target = jmp_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= BOOT;
            pc_reg        <= RESET_VECTOR;
            flush_cnt_reg <= 3'd0;
            flush_reg     <= 1'b0;
            align_err_reg <= 1'b0;
`ifdef PCSEQ_EXCEPTION_EN
            epc_reg       <= 32'd0;
            exc_pend_reg  <= 1'b0;
`endif
        end else begin
            flush_reg     <= 1'b0;
            align_err_reg <= 1'b0;
            unique case (state_reg)
                BOOT: begin
                    state_reg <= RUN;
`ifdef PCSEQ_EXCEPTION_EN
                    exc_pend_reg <= exc_req;
`endif
                end
                default: begin
`ifdef PCSEQ_EXCEPTION_EN
                    if (exc_take) begin
                        epc_reg       <= pc_reg;
                        pc_reg        <= EXC_VECTOR;
                        flush_reg     <= 1'b1;
                        flush_cnt_reg <= FLUSH_CNT_INIT;
                        state_reg     <= FLUSH;
                        exc_pend_reg  <= 1'b0;
                    end else
`endif
                    if (redirect) begin
                        // Redirects override stall and restart the bubble count even mid-FLUSH.
                        pc_reg        <= {redirect_target[31:2], 2'b00};
                        flush_reg     <= 1'b1;
                        align_err_reg <= |redirect_target[1:0];
                        flush_cnt_reg <= FLUSH_CNT_INIT;
                        state_reg     <= FLUSH;
                    end else if (state_reg == FLUSH) begin
                        flush_cnt_reg <= flush_cnt_reg - 3'd1;
                        if (flush_cnt_reg == 3'd1) begin
                            state_reg <= RUN;
                        end
                    end else if (!stall) begin
                        pc_reg <= pc_reg + 32'd4;
                    end
                end
            endcase
        end
    end

    assign pc_out    = pc_reg;
    assign pc_plus4  = pc_reg + 32'd4;
    // A stalled fetch repeats the same address; qualify it off in the same cycle so it is not consumed twice.
    assign if_valid  = (state_reg == RUN) & ~stall;
    assign flush     = flush_reg;
    assign align_err = align_err_reg;

endmodule
